// File: rtl/i2c_target_pkg.sv
// Shared types and bus constants for the I2C target responder.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRack,
    StIgnore
  } state_e;

  localparam logic Ack  = 1'b0;
  localparam logic Nack = 1'b1;

  // Position and meaning of the R/W bit in the address byte.
  localparam int unsigned RwBit  = 0;
  localparam logic        RwRead = 1'b1;

endpackage

// File: rtl/i2c_pin_filter.sv
// Two-flop synchronizer followed by a glitch filter: the output level follows
// the synchronized pin only after FILT consecutive samples disagree with it.
module i2c_pin_filter #(
  parameter int unsigned FILT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic level_o
);

  localparam int unsigned CntW = (FILT > 1) ? $clog2(FILT) : 1;

  logic [1:0]      sync_q;
  logic            level_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync_q <= {sync_q[0], pin_i};
      // Any sample matching the current level restarts the run count.
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntW'(FILT - 1)) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/i2c_target_responder.sv
// I2C target with a small byte register file for loopback checks of generated
// I2C patterns; answers by pulling SDA low through the IOBUF tristate control.
module i2c_target_responder
  import i2c_target_pkg::*;
#(
  parameter logic [6:0]   TARGET_ADDR = 7'h3C,
  parameter int unsigned  NREGS       = 8,
  parameter int unsigned  FILT        = 3,
  localparam int unsigned IdxW        = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               scl_i,
  input  logic               sda_i,
  output logic               sda_t,
  output logic [8*NREGS-1:0] regs_o,
  input  logic               host_we,
  input  logic [IdxW-1:0]    host_idx,
  input  logic [7:0]         host_data,
  output logic               wr_strobe,
  output logic [IdxW-1:0]    wr_idx,
  output logic               start_det,
  output logic               stop_det,
  output logic               busy
);

  logic scl_f, sda_f;
  logic scl_p_q, sda_p_q;
  logic scl_rise, scl_fall, start_ev, stop_ev;

  i2c_pin_filter #(.FILT(FILT)) u_scl_filter (
    .clk     (clk),
    .rst     (rst),
    .pin_i   (scl_i),
    .level_o (scl_f)
  );

  i2c_pin_filter #(.FILT(FILT)) u_sda_filter (
    .clk     (clk),
    .rst     (rst),
    .pin_i   (sda_i),
    .level_o (sda_f)
  );

  assign scl_rise = scl_f & ~scl_p_q;
  assign scl_fall = ~scl_f & scl_p_q;
  assign start_ev = scl_f & scl_p_q & sda_p_q & ~sda_f;
  assign stop_ev  = scl_f & scl_p_q & ~sda_p_q & sda_f;

  state_e                 state_q, state_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [6:0]             shift_q, shift_d;
  logic [IdxW-1:0]        ptr_q, ptr_d;
  logic                   sda_t_q, sda_t_d;
  logic                   ack_on_q, ack_on_d;
  logic                   load_q, load_d;
  logic                   rw_q, rw_d;
  logic                   busy_q, busy_d;
  logic                   wr_strobe_q, wr_strobe_d;
  logic [IdxW-1:0]        wr_idx_q, wr_idx_d;
  logic [7:0]             wr_data_q, wr_data_d;
  logic                   start_det_q, start_det_d;
  logic                   stop_det_q, stop_det_d;
  logic [NREGS-1:0][7:0]  regs_q;

  logic [7:0] rx_byte;
  logic [7:0] rd_byte;
  logic       last_bit;

  assign rx_byte  = {shift_q, sda_f};
  assign rd_byte  = regs_q[ptr_q];
  assign last_bit = (bit_cnt_q == 4'd7);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    sda_t_d     = sda_t_q;
    ack_on_d    = ack_on_q;
    load_d      = load_q;
    rw_d        = rw_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_idx_d    = wr_idx_q;
    wr_data_d   = wr_data_q;
    start_det_d = 1'b0;
    stop_det_d  = 1'b0;

    if (start_ev) begin
      state_d     = StAddr;
      bit_cnt_d   = '0;
      sda_t_d     = 1'b1;
      ack_on_d    = 1'b0;
      load_d      = 1'b0;
      busy_d      = 1'b1;
      start_det_d = 1'b1;
    end else if (stop_ev) begin
      state_d    = StIdle;
      bit_cnt_d  = '0;
      sda_t_d    = 1'b1;
      ack_on_d   = 1'b0;
      load_d     = 1'b0;
      busy_d     = 1'b0;
      stop_det_d = 1'b1;
    end else begin
      case (state_q)
        StAddr: begin
          if (scl_rise) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (last_bit) begin
              bit_cnt_d = '0;
              if (rx_byte[7:1] == TARGET_ADDR) begin
                rw_d    = rx_byte[RwBit];
                state_d = StAddrAck;
              end else begin
                state_d = StIgnore;
              end
            end
          end
        end
        StPtr: begin
          if (scl_rise) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (last_bit) begin
              bit_cnt_d = '0;
              ptr_d     = rx_byte[IdxW-1:0];
              state_d   = StPtrAck;
            end
          end
        end
        StWdata: begin
          if (scl_rise) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (last_bit) begin
              bit_cnt_d   = '0;
              wr_strobe_d = 1'b1;
              wr_idx_d    = ptr_q;
              wr_data_d   = rx_byte;
              ptr_d       = ptr_q + 1'b1;
              state_d     = StWdataAck;
            end
          end
        end
        StAddrAck, StPtrAck, StWdataAck: begin
          // First fall drives the ACK, second fall ends the ACK slot.
          if (scl_fall) begin
            if (!ack_on_q) begin
              sda_t_d  = Ack;
              ack_on_d = 1'b1;
            end else begin
              ack_on_d  = 1'b0;
              sda_t_d   = Nack;
              bit_cnt_d = '0;
              if (state_q != StAddrAck) begin
                state_d = StWdata;
              end else if (rw_q == RwRead) begin
                state_d = StRdata;
                shift_d = rd_byte[6:0];
                sda_t_d = rd_byte[7];
              end else begin
                state_d = StPtr;
              end
            end
          end
        end
        StRdata: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
          if (scl_fall) begin
            if (load_q) begin
              load_d    = 1'b0;
              bit_cnt_d = '0;
              shift_d   = rd_byte[6:0];
              sda_t_d   = rd_byte[7];
            end else if (bit_cnt_q == 4'd8) begin
              bit_cnt_d = '0;
              sda_t_d   = 1'b1;
              state_d   = StRack;
            end else begin
              sda_t_d = shift_q[6];
              shift_d = {shift_q[5:0], 1'b1};
            end
          end
        end
        StRack: begin
          if (scl_rise) begin
            ptr_d = ptr_q + 1'b1;
            if (sda_f == Ack) begin
              state_d = StRdata;
              load_d  = 1'b1;
            end else begin
              state_d = StIgnore;
            end
          end
        end
        StIgnore: begin
          sda_t_d = 1'b1;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      sda_t_q     <= 1'b1;
      ack_on_q    <= 1'b0;
      load_q      <= 1'b0;
      rw_q        <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_idx_q    <= '0;
      wr_data_q   <= '0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
      scl_p_q     <= 1'b1;
      sda_p_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      sda_t_q     <= sda_t_d;
      ack_on_q    <= ack_on_d;
      load_q      <= load_d;
      rw_q        <= rw_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_idx_q    <= wr_idx_d;
      wr_data_q   <= wr_data_d;
      start_det_q <= start_det_d;
      stop_det_q  <= stop_det_d;
      scl_p_q     <= scl_f;
      sda_p_q     <= sda_f;
    end
  end

  // The I2C commit is written last so it wins a same-index host write.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '0;
    end else begin
      if (host_we) begin
        regs_q[host_idx] <= host_data;
      end
      if (wr_strobe_q) begin
        regs_q[wr_idx_q] <= wr_data_q;
      end
    end
  end

  assign sda_t     = sda_t_q;
  assign regs_o    = regs_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_idx    = wr_idx_q;
  assign start_det = start_det_q;
  assign stop_det  = stop_det_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_responder.sv
// Bit-banged I2C initiator with scoreboards for bus responses and register commits.
module tb_i2c_target_responder;

  localparam int Q = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_line;
  logic        sda_t;
  logic [63:0] regs_o;
  logic        host_we = 1'b0;
  logic [2:0]  host_idx = '0;
  logic [7:0]  host_data = '0;
  logic        wr_strobe;
  logic [2:0]  wr_idx;
  logic        start_det, stop_det, busy;

  assign sda_line = sda_m & sda_t;

  always #5 clk = ~clk;

  i2c_target_responder #(
    .TARGET_ADDR (7'h3C),
    .NREGS       (8),
    .FILT        (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_m),
    .sda_i     (sda_line),
    .sda_t     (sda_t),
    .regs_o    (regs_o),
    .host_we   (host_we),
    .host_idx  (host_idx),
    .host_data (host_data),
    .wr_strobe (wr_strobe),
    .wr_idx    (wr_idx),
    .start_det (start_det),
    .stop_det  (stop_det),
    .busy      (busy)
  );

  typedef struct {
    int idx;
    int data;
  } wr_t;

  int    checks = 0;
  int    errors = 0;
  int    exp_bus_q[$];
  string exp_bus_nm[$];
  int    obs_bus_q[$];
  wr_t   exp_wr_q[$];
  logic [63:0] exp_regs = '0;
  int    exp_starts = 0;
  int    wr_cnt = 0, start_cnt = 0, stop_cnt = 0, sda_low_cnt = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_bus(input string nm, input int v);
    exp_bus_q.push_back(v);
    exp_bus_nm.push_back(nm);
  endtask

  task automatic expect_wr(input int idx, input int data);
    wr_t e;
    e.idx = idx;
    e.data = data;
    exp_wr_q.push_back(e);
    exp_regs[8*idx +: 8] = data[7:0];
  endtask

  task automatic i2c_bit(input logic b, output logic s);
    sda_m = b;
    cyc(Q);
    scl_m = 1'b1;
    cyc(Q);
    s = sda_line;
    cyc(Q);
    scl_m = 1'b0;
    cyc(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    cyc(Q);
    scl_m = 1'b1;
    cyc(2*Q);
    sda_m = 1'b0;
    cyc(2*Q);
    scl_m = 1'b0;
    cyc(Q);
    exp_starts++;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    cyc(Q);
    scl_m = 1'b1;
    cyc(2*Q);
    sda_m = 1'b1;
    cyc(2*Q);
  endtask

  task automatic write_byte(input logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) i2c_bit(d[i], s);
    i2c_bit(1'b1, s);
    obs_bus_q.push_back(int'(s));
  endtask

  task automatic read_byte(input logic ack);
    logic       s;
    logic [7:0] d;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, s);
      d[i] = s;
    end
    i2c_bit(ack, s);
    obs_bus_q.push_back(int'(d));
  endtask

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) wr_cnt <= wr_cnt + 1;
    if (start_det === 1'b1) start_cnt <= start_cnt + 1;
    if (stop_det === 1'b1) stop_cnt <= stop_cnt + 1;
    if (sda_t === 1'b0) sda_low_cnt <= sda_low_cnt + 1;
  end

  // Bus scoreboard: compares each completed byte slot with the queued expectation.
  initial forever begin
    @(negedge clk);
    if (obs_bus_q.size() != 0) begin
      int    o;
      o = obs_bus_q.pop_front();
      if (exp_bus_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bus_unexpected: got %0h, required no response", o);
      end else begin
        int    e;
        string nm;
        e  = exp_bus_q.pop_front();
        nm = exp_bus_nm.pop_front();
        check(nm, 64'(o), 64'(e));
      end
    end
  end

  // Commit scoreboard: index on the strobe, data on regs_o one cycle later.
  initial forever begin
    @(negedge clk);
    if (wr_strobe === 1'b1) begin
      if (exp_wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected: got idx %0d, required no write", wr_idx);
      end else begin
        wr_t e;
        e = exp_wr_q.pop_front();
        check("wr_idx", 64'(wr_idx), 64'(e.idx));
        @(negedge clk);
        check("wr_data", 64'(regs_o[8*e.idx +: 8]), 64'(e.data));
      end
    end
  end

  initial begin
    #2ms;
    errors++;
    $display("FAIL watchdog: got timeout, required completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int wr0, st0, low0;

    // Reset with pins idle.
    cyc(6);
    rst = 1'b0;
    @(negedge clk);
    check("reset_sda_t", 64'(sda_t), 64'(1));
    check("reset_regs", regs_o, 64'h0);
    check("reset_busy", 64'(busy), 64'(0));

    // Local host write.
    @(posedge clk);
    #1;
    host_we = 1'b1;
    host_idx = 3'd5;
    host_data = 8'hC3;
    @(posedge clk);
    #1;
    host_we = 1'b0;
    exp_regs[47:40] = 8'hC3;
    @(negedge clk);
    check("host_write", regs_o, exp_regs);

    // Pointer write: START 78 02 A5 5A STOP.
    wr0 = wr_cnt;
    expect_bus("pw_addr_ack", 0);
    expect_bus("pw_ptr_ack", 0);
    expect_bus("pw_d0_ack", 0);
    expect_bus("pw_d1_ack", 0);
    expect_wr(2, 8'hA5);
    expect_wr(3, 8'h5A);
    i2c_start();
    check("busy_in_xfer", 64'(busy), 64'(1));
    write_byte(8'h78);
    write_byte(8'h02);
    write_byte(8'hA5);
    write_byte(8'h5A);
    i2c_stop();
    cyc(10);
    check("pw_wr_count", 64'(wr_cnt - wr0), 64'(2));
    check("pw_regs", regs_o, exp_regs);
    check("pw_busy", 64'(busy), 64'(0));
    check("pw_stop_cnt", 64'(stop_cnt), 64'(1));

    // Repeated-START read, then IGNORE until STOP.
    expect_bus("rd_addr_ack", 0);
    expect_bus("rd_ptr_ack", 0);
    expect_bus("rd_raddr_ack", 0);
    expect_bus("rd_byte0", 8'hA5);
    expect_bus("rd_byte1", 8'h5A);
    expect_bus("rd_ignore_nack", 1);
    i2c_start();
    write_byte(8'h78);
    write_byte(8'h02);
    i2c_start();
    write_byte(8'h79);
    read_byte(1'b0);
    read_byte(1'b1);
    write_byte(8'h78);
    i2c_stop();
    cyc(10);
    check("rd_start_cnt", 64'(start_cnt), 64'(exp_starts));

    // Address mismatch: no ACK, SDA never pulled.
    low0 = sda_low_cnt;
    expect_bus("mm_addr_nack", 1);
    expect_bus("mm_data_nack", 1);
    i2c_start();
    write_byte(8'h7A);
    write_byte(8'h00);
    i2c_stop();
    cyc(10);
    check("mm_sda_low", 64'(sda_low_cnt - low0), 64'(0));
    check("mm_regs", regs_o, exp_regs);

    // Pointer wrap: ptr 7, data 11 then 22.
    expect_bus("wrap_addr_ack", 0);
    expect_bus("wrap_ptr_ack", 0);
    expect_bus("wrap_d0_ack", 0);
    expect_bus("wrap_d1_ack", 0);
    expect_wr(7, 8'h11);
    expect_wr(0, 8'h22);
    i2c_start();
    write_byte(8'h78);
    write_byte(8'h07);
    write_byte(8'h11);
    write_byte(8'h22);
    i2c_stop();
    cyc(10);
    check("wrap_regs", regs_o, exp_regs);

    // One-cycle SDA glitch with SCL high on an idle bus.
    st0 = start_cnt;
    sda_m = 1'b0;
    cyc(1);
    sda_m = 1'b1;
    cyc(20);
    check("glitch_start", 64'(start_cnt - st0), 64'(0));
    check("glitch_busy", 64'(busy), 64'(0));

    // STOP in the middle of a data byte.
    wr0 = wr_cnt;
    expect_bus("ms_addr_ack", 0);
    expect_bus("ms_ptr_ack", 0);
    i2c_start();
    write_byte(8'h78);
    write_byte(8'h01);
    begin
      logic s;
      i2c_bit(1'b1, s);
      i2c_bit(1'b0, s);
      i2c_bit(1'b1, s);
      i2c_bit(1'b0, s);
    end
    i2c_stop();
    cyc(10);
    check("ms_wr_count", 64'(wr_cnt - wr0), 64'(0));
    check("ms_busy", 64'(busy), 64'(0));
    check("ms_sda_t", 64'(sda_t), 64'(1));
    check("ms_regs", regs_o, exp_regs);

    cyc(20);
    check("bus_drain", 64'(exp_bus_q.size()), 64'(0));
    check("wr_drain", 64'(exp_wr_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
